// File: rtl/sdmac_pkg.sv
// Shared definitions for the SDMAC register-cycle sequencer.
//   - 3-bit state encoding for the host register-cycle FSM
//   - CNT_W: width of the wait counter shared by RWAIT and WD_ACC
//   - dec_t: decode inputs captured once in DECODE and held for the cycle
package sdmac_pkg;

  localparam int CNT_W = 4;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] RWAIT  = 3'd2;
  localparam logic [2:0] WD_REQ = 3'd3;
  localparam logic [2:0] WD_ACC = 3'd4;
  localparam logic [2:0] ACK    = 3'd5;

  // Latched decode, stored active high.
  typedef struct packed {
    logic rw;      // 1 = read
    logic wd;      // access targets the WD33C93
    logic reg_we;  // write to control or address-counter register
    logic st;
    logic sp;
    logic clr;
    logic flush;
  } dec_t;

endpackage

// File: rtl/reg_cycle_ctrl_ff_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high strobe.
// Ports:
//   clk   in  sampling clock
//   rst_n in  async active-low reset; both flops reset to 1 (strobe negated)
//   d     in  asynchronous input
//   q     out synchronised output
module ff_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old values
      // at the same edge, which is what forms the two-stage chain.
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/reg_cycle_ctrl.sv
// Host register-cycle sequencer for the SDMAC register block.
// Synchronises AS_/DMAC_, captures the address decode, times internal
// register and WD33C93 accesses, arbitrates the SCSI chip port with the DMA
// engine (PORT_REQ/PORT_GNT) and terminates each cycle with DSACK_.
// Ports:
//   SCLK, _RST                  clock, async active-low reset
//   AS_, DMAC_                  async CPU strobes (synchronised here)
//   RW, WDREGREQ, CONTR_WR, ACR_WR, ST_DMA, SP_DMA, CLR_INT, FLUSH_
//                               address decode, captured in DECODE
//   PORT_GNT                    SCSI port grant from the DMA engine
//   DSACK_, REG_OE, REG_WE      cycle ack, read-data enable, write strobe
//   ST_P, SP_P, CLR_P, FLUSH_P  one-cycle command pulses
//   PORT_REQ, CSS_              SCSI port request, WD33C93 chip select
// All outputs are flops fed from the current state, so each trails the state
// register by one edge.
module reg_cycle_ctrl
  import sdmac_pkg::*;
#(
  parameter int REG_WAIT = 1,
  parameter int WD_WAIT  = 3
) (
  input  logic SCLK,
  input  logic _RST,
  input  logic AS_,
  input  logic DMAC_,
  input  logic RW,
  input  logic WDREGREQ,
  input  logic CONTR_WR,
  input  logic ACR_WR,
  input  logic ST_DMA,
  input  logic SP_DMA,
  input  logic CLR_INT,
  input  logic FLUSH_,
  input  logic PORT_GNT,
  output logic DSACK_,
  output logic REG_OE,
  output logic REG_WE,
  output logic ST_P,
  output logic SP_P,
  output logic CLR_P,
  output logic FLUSH_P,
  output logic PORT_REQ,
  output logic CSS_
);

  logic as_s;
  logic dmac_s;
  logic cyc;
  logic abort;
  logic first_ack;

  logic [2:0]       state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  dec_t             dec_q,      dec_d;
  logic             dsack_n_q,  dsack_n_d;
  logic             reg_oe_q,   reg_oe_d;
  logic             reg_we_q,   reg_we_d;
  logic             st_p_q,     st_p_d;
  logic             sp_p_q,     sp_p_d;
  logic             clr_p_q,    clr_p_d;
  logic             flush_p_q,  flush_p_d;
  logic             port_req_q, port_req_d;
  logic             css_n_q,    css_n_d;

  ff_sync u_sync_as   (.clk(SCLK), .rst_n(_RST), .d(AS_),   .q(as_s));
  ff_sync u_sync_dmac (.clk(SCLK), .rst_n(_RST), .d(DMAC_), .q(dmac_s));

  assign cyc   = !as_s && !dmac_s;
  assign abort = as_s;

  // Sequencer.
  always_comb begin
    // NOTE: every variable gets a hold default before the case so that no
    // path leaves it unassigned and a latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    case (state_q)
      IDLE: if (cyc) state_d = DECODE;
      DECODE: begin
        dec_d = '{rw:     RW,
                  wd:     WDREGREQ,
                  reg_we: !RW && (CONTR_WR || ACR_WR),
                  st:     ST_DMA,
                  sp:     SP_DMA,
                  clr:    CLR_INT,
                  flush:  !FLUSH_};
        if (abort)              state_d = IDLE;
        else if (WDREGREQ)      state_d = WD_REQ;
        else if (REG_WAIT == 0) state_d = ACK;
        else begin
          cnt_d   = CNT_W'(REG_WAIT - 1);
          state_d = RWAIT;
        end
      end
      RWAIT, WD_ACC: begin
        if (abort)             state_d = IDLE;
        else if (cnt_q == '0)  state_d = ACK;
        else                   cnt_d   = cnt_q - CNT_W'(1);
      end
      // Abort is tested first so a grant arriving with it is ignored.
      WD_REQ: begin
        if (abort) state_d = IDLE;
        else if (PORT_GNT) begin
          cnt_d   = CNT_W'(WD_WAIT - 1);
          state_d = WD_ACC;
        end
      end
      ACK:     if (abort) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next values. DSACK_ is still high during the first ACK cycle,
  // which marks ACK entry for the one-shot pulses.
  always_comb begin
    first_ack  = (state_q == ACK) && dsack_n_q;
    dsack_n_d  = (state_q != ACK);
    reg_oe_d   = (state_q == ACK) && dec_q.rw;
    reg_we_d   = first_ack && dec_q.reg_we;
    st_p_d     = first_ack && dec_q.st;
    sp_p_d     = first_ack && dec_q.sp;
    clr_p_d    = first_ack && dec_q.clr;
    flush_p_d  = first_ack && dec_q.flush;
    // Abort releases the SCSI port on the same edge the FSM leaves; in ACK
    // the request follows DSACK_ instead.
    port_req_d = (((state_q == WD_REQ) || (state_q == WD_ACC)) && !abort) ||
                 ((state_q == ACK) && dec_q.wd);
    css_n_d    = !((state_q == WD_ACC) && !abort);
  end

  always_ff @(posedge SCLK or negedge _RST) begin
    if (!_RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dec_q      <= '0;
      dsack_n_q  <= 1'b1;
      reg_oe_q   <= 1'b0;
      reg_we_q   <= 1'b0;
      st_p_q     <= 1'b0;
      sp_p_q     <= 1'b0;
      clr_p_q    <= 1'b0;
      flush_p_q  <= 1'b0;
      port_req_q <= 1'b0;
      css_n_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dec_q      <= dec_d;
      dsack_n_q  <= dsack_n_d;
      reg_oe_q   <= reg_oe_d;
      reg_we_q   <= reg_we_d;
      st_p_q     <= st_p_d;
      sp_p_q     <= sp_p_d;
      clr_p_q    <= clr_p_d;
      flush_p_q  <= flush_p_d;
      port_req_q <= port_req_d;
      css_n_q    <= css_n_d;
    end
  end

  assign DSACK_   = dsack_n_q;
  assign REG_OE   = reg_oe_q;
  assign REG_WE   = reg_we_q;
  assign ST_P     = st_p_q;
  assign SP_P     = sp_p_q;
  assign CLR_P    = clr_p_q;
  assign FLUSH_P  = flush_p_q;
  assign PORT_REQ = port_req_q;
  assign CSS_     = css_n_q;

endmodule

// File: tb/tb_reg_cycle_ctrl.sv
// Directed bench for reg_cycle_ctrl (REG_WAIT=1, WD_WAIT=3).
// Comments "cN" name the DUT edge relative to cycle 0 of the current access;
// outputs are sampled 1 ns after each rising edge.
module tb_reg_cycle_ctrl;

  logic SCLK = 1'b0;
  logic _RST, AS_, DMAC_, RW, WDREGREQ, CONTR_WR, ACR_WR;
  logic ST_DMA, SP_DMA, CLR_INT, FLUSH_, PORT_GNT;
  logic DSACK_, REG_OE, REG_WE, ST_P, SP_P, CLR_P, FLUSH_P, PORT_REQ, CSS_;

  int errors = 0;
  int checks = 0;

  // Activity monitor, updated on every sample.
  logic css_low_seen, dsack_low_seen, pulse_seen, dsack_prev;
  int   flush_cnt, dsack_falls;

  reg_cycle_ctrl #(.REG_WAIT(1), .WD_WAIT(3)) dut (
    .SCLK(SCLK), ._RST(_RST), .AS_(AS_), .DMAC_(DMAC_), .RW(RW),
    .WDREGREQ(WDREGREQ), .CONTR_WR(CONTR_WR), .ACR_WR(ACR_WR),
    .ST_DMA(ST_DMA), .SP_DMA(SP_DMA), .CLR_INT(CLR_INT), .FLUSH_(FLUSH_),
    .PORT_GNT(PORT_GNT), .DSACK_(DSACK_), .REG_OE(REG_OE), .REG_WE(REG_WE),
    .ST_P(ST_P), .SP_P(SP_P), .CLR_P(CLR_P), .FLUSH_P(FLUSH_P),
    .PORT_REQ(PORT_REQ), .CSS_(CSS_)
  );

  always #5 SCLK = ~SCLK;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    css_low_seen   = 1'b0;
    dsack_low_seen = 1'b0;
    pulse_seen     = 1'b0;
    flush_cnt      = 0;
    dsack_falls    = 0;
    dsack_prev     = DSACK_;
  endtask

  task automatic tick();
    @(posedge SCLK);
    #1;
    if (CSS_ === 1'b0)   css_low_seen   = 1'b1;
    if (DSACK_ === 1'b0) dsack_low_seen = 1'b1;
    if ((REG_WE | ST_P | SP_P | CLR_P | FLUSH_P) === 1'b1) pulse_seen = 1'b1;
    if (FLUSH_P === 1'b1) flush_cnt++;
    if (dsack_prev === 1'b1 && DSACK_ === 1'b0) dsack_falls++;
    dsack_prev = DSACK_;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drops AS_/DMAC_ with the given decode; returns just after cycle 0.
  task automatic start_cycle(input logic rw, input logic wd, input logic contr,
                             input logic st, input logic flush_n);
    RW       = rw;
    WDREGREQ = wd;
    CONTR_WR = contr;
    ST_DMA   = st;
    FLUSH_   = flush_n;
    AS_      = 1'b0;
    DMAC_    = 1'b0;
    ticks(3);
  endtask

  task automatic end_cycle();
    AS_      = 1'b1;
    DMAC_    = 1'b1;
    RW       = 1'b0;
    WDREGREQ = 1'b0;
    CONTR_WR = 1'b0;
    ST_DMA   = 1'b0;
    FLUSH_   = 1'b1;
  endtask

  initial begin
    _RST = 1'b0; AS_ = 1'b1; DMAC_ = 1'b1; RW = 1'b0; WDREGREQ = 1'b0;
    CONTR_WR = 1'b0; ACR_WR = 1'b0; ST_DMA = 1'b0; SP_DMA = 1'b0;
    CLR_INT = 1'b0; FLUSH_ = 1'b1; PORT_GNT = 1'b0;
    #12;
    check("rst dsack",    DSACK_,   1'b1);
    check("rst css",      CSS_,     1'b1);
    check("rst port_req", PORT_REQ, 1'b0);
    check("rst reg_oe",   REG_OE,   1'b0);
    check("rst pulses",   {REG_WE, ST_P, SP_P, CLR_P, FLUSH_P}, 5'b0);
    @(negedge SCLK);
    _RST = 1'b1;
    ticks(2);

    // Register write to the control register.
    start_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();                                   // c1
    tick();                                   // c2
    check("wr c2 dsack", DSACK_, 1'b1);
    check("wr c2 we",    REG_WE, 1'b0);
    tick();                                   // c3
    check("wr c3 dsack", DSACK_, 1'b0);
    check("wr c3 we",    REG_WE, 1'b1);
    check("wr c3 oe",    REG_OE, 1'b0);
    tick();                                   // c4
    check("wr c4 we",    REG_WE, 1'b0);
    check("wr c4 dsack", DSACK_, 1'b0);
    end_cycle();
    ticks(3);                                 // c7: abort seen in ACK
    check("wr c7 dsack", DSACK_, 1'b0);
    tick();                                   // c8
    check("wr c8 dsack", DSACK_, 1'b1);

    // Read at the ST_DMA address.
    start_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    ticks(2);                                 // c2
    check("st c2 st_p",  ST_P,   1'b0);
    check("st c2 oe",    REG_OE, 1'b0);
    tick();                                   // c3
    check("st c3 dsack", DSACK_, 1'b0);
    check("st c3 st_p",  ST_P,   1'b1);
    check("st c3 oe",    REG_OE, 1'b1);
    check("st c3 we",    REG_WE, 1'b0);
    tick();                                   // c4
    check("st c4 st_p",  ST_P,   1'b0);
    check("st c4 oe",    REG_OE, 1'b1);
    end_cycle();
    ticks(3);                                 // c7
    check("st c7 oe",    REG_OE, 1'b1);
    tick();                                   // c8
    check("st c8 oe",    REG_OE, 1'b0);

    // WD33C93 access, grant seen at c7.
    start_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    ticks(2);                                 // c2
    check("wd c2 req",   PORT_REQ, 1'b1);
    check("wd c2 css",   CSS_,     1'b1);
    ticks(4);                                 // c6
    PORT_GNT = 1'b1;
    tick();                                   // c7
    check("wd c7 css",   CSS_,     1'b1);
    PORT_GNT = 1'b0;                          // drop is ignored in WD_ACC
    tick();                                   // c8
    check("wd c8 css",   CSS_,     1'b0);
    tick();                                   // c9
    check("wd c9 css",   CSS_,     1'b0);
    tick();                                   // c10
    check("wd c10 css",  CSS_,     1'b0);
    check("wd c10 dsack", DSACK_,  1'b1);
    tick();                                   // c11
    check("wd c11 css",  CSS_,     1'b1);
    check("wd c11 dsack", DSACK_,  1'b0);
    check("wd c11 req",  PORT_REQ, 1'b1);
    check("wd c11 we",   REG_WE,   1'b0);
    end_cycle();
    ticks(3);                                 // c14
    check("wd c14 req",  PORT_REQ, 1'b1);
    tick();                                   // c15
    check("wd c15 req",  PORT_REQ, 1'b0);
    check("wd c15 dsack", DSACK_,  1'b1);

    // Abort in WD_REQ with grant on the same edge.
    start_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    clear_mon();
    ticks(2);                                 // c2
    check("ab c2 req",   PORT_REQ, 1'b1);
    end_cycle();
    ticks(2);                                 // c4
    PORT_GNT = 1'b1;
    tick();                                   // c5: abort and grant
    check("ab c5 req",   PORT_REQ, 1'b0);
    check("ab c5 css",   CSS_,     1'b1);
    ticks(3);
    PORT_GNT = 1'b0;
    check("ab css low",   css_low_seen,   1'b0);
    check("ab dsack low", dsack_low_seen, 1'b0);
    check("ab pulses",    pulse_seen,     1'b0);

    // Reset during WD_ACC, then a normal write.
    PORT_GNT = 1'b1;
    start_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    ticks(3);                                 // c3
    check("rs c3 css",   CSS_, 1'b0);
    #3 _RST = 1'b0;
    #1;
    check("rs css",      CSS_,     1'b1);
    check("rs dsack",    DSACK_,   1'b1);
    check("rs req",      PORT_REQ, 1'b0);
    end_cycle();
    PORT_GNT = 1'b0;
    #2 _RST = 1'b1;
    ticks(3);
    check("rs idle dsack", DSACK_, 1'b1);
    check("rs idle css",   CSS_,   1'b1);
    start_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    ticks(3);                                 // c3
    check("rs2 c3 dsack", DSACK_, 1'b0);
    check("rs2 c3 we",    REG_WE, 1'b1);
    end_cycle();
    ticks(5);

    // Two back-to-back FLUSH_ reads with AS_ high for one clock.
    start_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    clear_mon();
    ticks(3);                                 // c3
    check("bb c3 dsack", DSACK_, 1'b0);
    AS_ = 1'b1; DMAC_ = 1'b1;
    tick();                                   // c4
    AS_ = 1'b0; DMAC_ = 1'b0;
    ticks(3);                                 // c7: back in IDLE one cycle
    check("bb c7 dsack", DSACK_, 1'b1);
    ticks(3);                                 // c10: second ACK
    check("bb c10 dsack", DSACK_, 1'b0);
    end_cycle();
    ticks(5);
    check("bb flush pulses", flush_cnt,   32'd2);
    check("bb dsack falls",  dsack_falls, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_cycle_ctrl.md
# reg_cycle_ctrl

Host register-cycle sequencer for the SDMAC register block. It synchronises the CPU bus strobes, and qualifies the combinational address-decode outputs. It sequences internal register accesses and WD33C93 (SCSI chip) accesses, and terminates each cycle with DSACK_. WD33C93 accesses share the SCSI chip port with the DMA engine through a request/grant handshake.

## Interface
Parameters:
- REG_WAIT, 1: wait cycles for internal register accesses (0..15).
- WD_WAIT, 3: cycles CSS_ is held low for a WD33C93 access (1..15).

Ports:
- SCLK  in  1  system clock; all state updates on rising edge.
- _RST  in  1  asynchronous, active-low reset.
- AS_  in  1  CPU address strobe, asynchronous; 2-flop synchronised internally.
- DMAC_  in  1  SDMAC chip select, asynchronous; 2-flop synchronised internally.
- RW  in  1  1 = read, 0 = write; sampled in DECODE.
- WDREGREQ  in  1  decode: access targets the WD33C93.
- CONTR_WR, ACR_WR  in  1 each  decode: control / address-counter register write.
- ST_DMA, SP_DMA, CLR_INT, FLUSH_  in  1 each  decode: command addresses (FLUSH_ active low).
- PORT_GNT  in  1  DMA engine grants the SCSI chip port.
- DSACK_  out  1  cycle acknowledge, active low.
- REG_OE  out  1  drive register read data onto the CPU bus.
- REG_WE  out  1  one-cycle register write strobe.
- ST_P, SP_P, CLR_P, FLUSH_P  out  1 each  one-cycle command pulses, active high.
- PORT_REQ  out  1  request the SCSI chip port.
- CSS_  out  1  WD33C93 chip select, active low.

## Operation
- Reset values: DSACK_=1, CSS_=1, all other outputs 0. State=IDLE, counter=0, synchroniser flops=1.
- "cyc" means synchronised AS_=0 and DMAC_=0. "abort" means synchronised AS_=1.
- IDLE: when cyc, go to DECODE.
- DECODE (1 cycle): latch RW and all decode inputs.
  - If WDREGREQ, go to WD_REQ.
  - Else if REG_WAIT=0, go to ACK.
  - Else load the counter with REG_WAIT-1 and go to RWAIT.
- RWAIT: decrement the counter; at 0, go to ACK.
- WD_REQ: PORT_REQ=1. When PORT_GNT=1, load the counter with WD_WAIT-1 and go to WD_ACC.
- WD_ACC: CSS_=0 and PORT_REQ=1. Decrement the counter; at 0, go to ACK.
- ACK: DSACK_=0; REG_OE=1 if latched RW=1; PORT_REQ stays 1 if this was a WD access. Hold until abort, then go to IDLE.
- Entry to ACK fires these pulses for exactly one cycle, from latched values:
  - REG_WE if RW=0 and (CONTR_WR or ACR_WR).
  - ST_P, SP_P, CLR_P for ST_DMA, SP_DMA, CLR_INT respectively, on reads and writes alike.
  - FLUSH_P for FLUSH_=0, on reads and writes alike.
- Abort in DECODE, RWAIT, WD_REQ or WD_ACC: go to IDLE next edge. No pulses fire, DSACK_ never asserts, and CSS_/PORT_REQ release on that edge.
- Simultaneous PORT_GNT and abort in WD_REQ: abort wins.
- PORT_GNT dropping during WD_ACC is ignored; the access completes.
- Back-to-back cycles: IDLE always lasts at least one cycle after ACK, so a new cyc is not accepted on the ACK-exit edge.
- Reset mid-cycle forces the reset values immediately, asynchronously.

## Timing
- Cycle 0 is the first edge where synchronised cyc=1 in IDLE; the AS_ pin falls 2 edges earlier.
- Register access: DECODE at cycle 1. DSACK_ falls at cycle 2+REG_WAIT, so at cycle 2 when REG_WAIT=0 and at cycle 3 when REG_WAIT=1.
- WD access: PORT_REQ rises at cycle 2.
  - If grant is seen at cycle k, CSS_ is low for cycles k+1 .. k+WD_WAIT.
  - DSACK_ falls at k+WD_WAIT+1.
  - CSS_ rises on the same edge DSACK_ falls.
- DSACK_, REG_OE and PORT_REQ deassert on the edge after synchronised AS_=1 is seen in ACK.
- All outputs are registered; none are combinational from inputs.

## Structure
- Shared package sdmac_pkg holds:
  - state encoding localparams IDLE, DECODE, RWAIT, WD_REQ, WD_ACC, ACK (3 bits);
  - counter width constant CNT_W=4.
- One sub-module, ff_sync: 2-flop synchroniser with reset value 1, instantiated for AS_ and DMAC_.
- The counter is shared between RWAIT and WD_ACC.

## Test plan
- Write at CONTR_WR, REG_WAIT=1: DSACK_ low at cycle 3; REG_WE high only at cycle 3; REG_OE stays 0; release 1 cycle after AS_ rises.
- Read at the ST_DMA address: ST_P is a single pulse at DSACK_ fall; REG_OE=1 throughout ACK; no REG_WE.
- WD access with PORT_GNT delayed 5 cycles: PORT_REQ from cycle 2; CSS_ low for exactly 3 cycles after grant; DSACK_ falls on the edge CSS_ rises.
- AS_ negated during WD_REQ while PORT_GNT rises on the same edge: return to IDLE; CSS_ never low; DSACK_ never low; no pulses.
- _RST asserted during WD_ACC: CSS_=1, DSACK_=1, PORT_REQ=0 immediately; IDLE after release; the next cycle completes normally.
- Two back-to-back FLUSH_ reads: exactly two FLUSH_P pulses; at least one IDLE cycle between the two ACK states.
